// File: rtl/rf_pkg.sv
// Shared types and sizing helpers for the digit-serial register file
// and the serial datapath sequencers built around it.
package rf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_NUM_REGS = 16;

    // Index width for n items, never below one bit so a 1-digit build still has a counter.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_rf_counter.sv
// Digit counter with last-digit flag; wraps to zero on the final digit.
import rf_pkg::*;

module serial_rf_counter #(
    parameter int NDIG  = 32,
    parameter int CNT_W = sel_width(NDIG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    assign last = (cnt == CNT_W'(NDIG - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (en)
            cnt <= last ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/serial_regfile_seq.sv
// Self-sequenced digit-serial register file: two serial read ports and one
// serial write port per full-word transaction, MSB digit first.
import rf_pkg::*;

module serial_regfile_seq #(
    parameter int  WIDTH    = DEF_WIDTH,
    parameter int  NUM_REGS = DEF_NUM_REGS,
    parameter int  DIGIT    = 1,
    localparam int SEL_W    = sel_width(NUM_REGS),
    localparam int NDIG     = WIDTH / DIGIT,
    localparam int CNT_W    = sel_width(NDIG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SEL_W-1:0] r_sel1,
    input  logic [SEL_W-1:0] r_sel2,
    input  logic [SEL_W-1:0] write_register,
    input  logic             wr_en,
    input  logic [DIGIT-1:0] write_value,
    output logic [DIGIT-1:0] r_value1,
    output logic [DIGIT-1:0] r_value2,
    output logic [CNT_W-1:0] digit_idx,
    output logic             busy,
    output logic             done
);

    typedef struct packed {
        logic [SEL_W-1:0] sel1;
        logic [SEL_W-1:0] sel2;
        logic [SEL_W-1:0] wsel;
        logic             wr_en;
    } txn_t;

    state_t state, state_nx;
    txn_t   txn;
    logic   accept, last;

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic [NUM_REGS-1:0][WIDTH-1:0] rot_nx;

    assign accept = (state == IDLE) && start;
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);

    serial_rf_counter #(.NDIG(NDIG), .CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (busy),
        .cnt   (digit_idx),
        .last  (last)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Rotate-left by one digit; the write target takes the incoming digit in
    // place of the one it rotates out. Slot 0 stays zero.
    always_comb begin
        rot_nx = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            rot_nx[i] = (regs[i] << DIGIT) | (regs[i] >> (WIDTH - DIGIT));
            if (txn.wr_en && (txn.wsel == SEL_W'(i)))
                rot_nx[i][DIGIT-1:0] = write_value;
        end
    end

    // Top digit is presented before the edge that replaces it, so a read of
    // the write target still returns the old word.
    assign r_value1 = busy ? regs[txn.sel1][WIDTH-1 -: DIGIT] : '0;
    assign r_value2 = busy ? regs[txn.sel2][WIDTH-1 -: DIGIT] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            txn   <= '0;
            regs  <= '0;
        end else begin
            state <= state_nx;
            if (accept)
                txn <= '{sel1: r_sel1, sel2: r_sel2, wsel: write_register, wr_en: wr_en};
            if (busy)
                regs <= rot_nx;
        end
    end

endmodule

// File: tb/tb_serial_regfile_seq.sv
// Scoreboard bench: a DIGIT=1 and a DIGIT=4 instance checked against a word model.
module tb_serial_regfile_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       start, wr_en, wv, rv1, rv2, busy, done;
    logic [3:0] r_sel1, r_sel2, wreg;
    logic [4:0] idx;

    logic       start4, wr_en4, busy4, done4;
    logic [3:0] sel1_4, sel2_4, wreg4, wv4, rv1_4, rv2_4;
    logic [2:0] idx4;

    serial_regfile_seq #(.WIDTH(32), .NUM_REGS(16), .DIGIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .r_sel1(r_sel1), .r_sel2(r_sel2),
        .write_register(wreg), .wr_en(wr_en), .write_value(wv),
        .r_value1(rv1), .r_value2(rv2), .digit_idx(idx), .busy(busy), .done(done)
    );

    serial_regfile_seq #(.WIDTH(32), .NUM_REGS(16), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .r_sel1(sel1_4), .r_sel2(sel2_4),
        .write_register(wreg4), .wr_en(wr_en4), .write_value(wv4),
        .r_value1(rv1_4), .r_value2(rv2_4), .digit_idx(idx4), .busy(busy4), .done(done4)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] mdl [16];
    logic        q1 [$];
    logic        q2 [$];
    logic [3:0]  q4 [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One DIGIT=1 transaction; expected read digits come from the model before the write.
    task automatic run_txn(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] w,
                           input logic we, input logic [31:0] wd, input bit poke);
        logic e1, e2;
        for (int k = 31; k >= 0; k--) begin
            q1.push_back(mdl[s1][k]);
            q2.push_back(mdl[s2][k]);
        end
        r_sel1 = s1; r_sel2 = s2; wreg = w; wr_en = we; start = 1'b1;
        @(negedge clk);
        r_sel1 = 4'($urandom); r_sel2 = 4'($urandom); wreg = 4'($urandom); wr_en = 1'($urandom);
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            wv = wd[31-k];
            start = (poke && k == 5);
            n_cmp++;
            if (busy !== 1'b1 || idx !== 5'(k)) begin
                n_err++;
                $display("FAIL shift_state: busy=%b idx=%0d want busy=1 idx=%0d", busy, idx, k);
            end
            e1 = q1.pop_front();
            e2 = q2.pop_front();
            n_cmp++;
            if (rv1 !== e1) begin
                n_err++;
                $display("FAIL r_value1 x%0d digit %0d: got %b want %b", s1, k, rv1, e1);
            end
            n_cmp++;
            if (rv2 !== e2) begin
                n_err++;
                $display("FAIL r_value2 x%0d digit %0d: got %b want %b", s2, k, rv2, e2);
            end
        end
        @(negedge clk);
        start = poke;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_pulse: done=%b busy=%b want 1/0", done, busy);
        end
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || idx !== 5'd0) begin
            n_err++;
            $display("FAIL post_done_idle: done=%b busy=%b idx=%0d want 0/0/0", done, busy, idx);
        end
        if (we && w != 4'd0) mdl[w] = wd;
    endtask

    task automatic run_txn4(input logic [3:0] s1, input logic [3:0] w, input logic we,
                            input logic [31:0] wd, input logic [31:0] exp1);
        logic [3:0] e;
        for (int k = 7; k >= 0; k--) q4.push_back(exp1[4*k +: 4]);
        sel1_4 = s1; sel2_4 = 4'd0; wreg4 = w; wr_en4 = we; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            wv4 = wd[31-4*k -: 4];
            e = q4.pop_front();
            chk("d4_busy", {31'd0, busy4}, 32'd1);
            chk("d4_idx", {29'd0, idx4}, 32'(k));
            chk("d4_r_value1", {28'd0, rv1_4}, {28'd0, e});
            chk("d4_r_value2_x0", {28'd0, rv2_4}, 32'd0);
        end
        @(negedge clk);
        chk("d4_busy_end", {31'd0, busy4}, 32'd0);
        chk("d4_done", {31'd0, done4}, 32'd1);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; r_sel1 = 0; r_sel2 = 0; wreg = 0; wr_en = 0; wv = 0;
        start4 = 0; sel1_4 = 0; sel2_4 = 0; wreg4 = 0; wr_en4 = 0; wv4 = 0;
        for (int i = 0; i < 16; i++) mdl[i] = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_idx", {27'd0, idx}, 32'd0);
        chk("reset_rv", {30'd0, rv1, rv2}, 32'd0);
        chk("reset_busy4", {31'd0, busy4}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_after_reset();
        run_txn(4'd3, 4'd0, 4'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_write();
        run_txn(4'd4, 4'd0, 4'd5, 1'b1, 32'hDEADBEEF, 1'b0);
        chk("model_x5", mdl[5], 32'hDEADBEEF);
        run_txn(4'd5, 4'd4, 4'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_same_reg();
        run_txn(4'd0, 4'd0, 4'd7, 1'b1, 32'h12345678, 1'b0);
        run_txn(4'd7, 4'd5, 4'd7, 1'b1, 32'hFFFF0000, 1'b0);
        run_txn(4'd7, 4'd5, 4'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_x0();
        run_txn(4'd0, 4'd5, 4'd0, 1'b1, 32'hFFFFFFFF, 1'b0);
        run_txn(4'd0, 4'd7, 4'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn(4'd5, 4'd7, 4'd9, 1'b1, 32'h0F1E2D3C, 1'b0);
        run_txn(4'd9, 4'd9, 4'd15, 1'b1, 32'h80000001, 1'b0);
        run_txn(4'd15, 4'd9, 4'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_txn(4'd9, 4'd15, 4'd3, 1'b1, 32'hCAFEF00D, 1'b1);
        run_txn(4'd3, 4'd5, 4'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_digit4();
        run_txn4(4'd1, 4'd1, 1'b1, 32'hA5A5A5A5, 32'd0);
        run_txn4(4'd1, 4'd0, 1'b0, 32'd0, 32'hA5A5A5A5);
    endtask

    task automatic test_reset_mid();
        r_sel1 = 4'd5; r_sel2 = 4'd7; wreg = 4'd2; wr_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wv = 1'b1;
            @(negedge clk);
        end
        chk("mid_idx_before_reset", {27'd0, idx}, 32'd10);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_busy", {31'd0, busy}, 32'd0);
        chk("mid_reset_idx", {27'd0, idx}, 32'd0);
        chk("mid_reset_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mdl[i] = 32'd0;
        @(negedge clk);
        run_txn(4'd5, 4'd7, 4'd0, 1'b0, 32'd0, 1'b0);
        run_txn(4'd2, 4'd3, 4'd0, 1'b0, 32'd0, 1'b0);
        run_txn(4'd9, 4'd15, 4'd0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_write();
        test_same_reg();
        test_x0();
        test_back_to_back();
        test_ignore_start();
        test_digit4();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
